// File: rtl/concat_rr_packer.sv
// concat_rr_packer: two-requester round-robin arbiter that prefixes an 8-bit
// header {marker, src, parity, seq} onto a 24-bit payload.
// The result is held in a single registered valid/ready output stage.
module concat_rr_packer #(
    parameter int BITS  = 32,
    parameter int SEQ_W = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            a_valid,
    input  logic [BITS-9:0] a,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [BITS-9:0] b,
    output logic            b_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out,
    output logic            last_src
);

    localparam int PW = BITS - 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BITS-1:0]     out_q, out_d;
    logic                last_src_q, last_src_d;

    logic                accept;
    logic                grant_a;
    logic                grant_b;
    logic [1:0]          grant_vec;
    logic [PW-1:0]       payload_sel;
    logic [SEQ_W-1:0]    seq_sel;
    logic [2*SEQ_W-1:0]  seq_cur;

    // Arbitration and readies: a tie goes to the source that did not win last time.
    // Nothing is granted while reset is asserted.
    always_comb begin
        accept  = (state_q == EMPTY) || out_ready;
        grant_a = reset_n && accept && a_valid && (!b_valid || last_src_q);
        grant_b = reset_n && accept && b_valid && (!a_valid || !last_src_q);
        a_ready = grant_a;
        b_ready = grant_b;
    end

    assign grant_vec = {grant_b, grant_a};

    // One sequence counter per source; only the granted source advances.
    // The counter wraps naturally at 2**SEQ_W.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_seq
            logic [SEQ_W-1:0] seq_q, seq_d;

            // Advance this source's counter when it is granted.
            always_comb begin
                seq_d = seq_q;
                if (grant_vec[gi]) begin
                    seq_d = seq_q + 1'b1;
                end
            end

            // Counter register, cleared on reset.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    seq_q <= '0;
                end else begin
                    seq_q <= seq_d;
                end
            end

            assign seq_cur[gi*SEQ_W +: SEQ_W] = seq_q;
        end
    endgenerate

    // Select the payload and the pre-increment sequence value of the granted source.
    always_comb begin
        payload_sel = a;
        seq_sel     = seq_cur[0 +: SEQ_W];
        if (grant_b) begin
            payload_sel = b;
            seq_sel     = seq_cur[SEQ_W +: SEQ_W];
        end
    end

    // Next-state logic: a grant loads a new word, even while the old word drains.
    // A drain without a grant empties the stage, and backpressure holds everything.
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        last_src_d = last_src_q;
        if (grant_a || grant_b) begin
            out_d      = {1'b1, grant_b, ^payload_sel, seq_sel, payload_sel};
            last_src_d = grant_b;
            state_d    = FULL;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    // State, output word and last-grant registers.
    // last_src resets to B so that A wins the first tie.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            out_q      <= '0;
            last_src_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            last_src_q <= last_src_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out       = out_q;
    assign last_src  = last_src_q;

endmodule

// File: doc/concat_rr_packer.md
Name: concat_rr_packer

Overview:
- Two-requester round-robin arbiter and sequencer for a shared header-concatenation datapath.
- Each requester offers a 24-bit payload over a valid/ready handshake.
- The block grants one requester per transfer and builds a 32-bit word by concatenating a generated 8-bit header onto the payload.
- Output is a single registered valid/ready stage, placed between narrow producers and a 32-bit sink.

Parameters:
- BITS, 32, output word width; payload width is BITS-8, header width is 8.
- SEQ_W, 5, per-source sequence counter width; fixed at 5 so the header is exactly 8 bits.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clock.
- a_valid  input  1  requester A has a payload.
- a  input  BITS-8  requester A payload.
- a_ready  output  1  A's payload is taken this cycle (combinational).
- b_valid  input  1  requester B has a payload.
- b  input  BITS-8  requester B payload.
- b_ready  output  1  B's payload is taken this cycle (combinational).
- out_valid  output  1  out holds a valid word.
- out_ready  input  1  sink accepts out this cycle.
- out  output  BITS  packed word.
- last_src  output  1  source of the most recent grant (0=A, 1=B).

Behaviour:
- Reset (reset_n=0 at posedge):
  - out_valid=0, out=0, last_src=1 (so A wins the first tie).
  - Both sequence counters = 0. FSM -> EMPTY.
  - Reset mid-transfer discards the held word; no handshake completes in a reset cycle.
  - a_ready=b_ready=0 while reset_n=0.
- FSM states:
  - EMPTY: output register free.
  - FULL: out_valid=1, word held.
- accept = (state==EMPTY) || out_ready. The register can be refilled in the same cycle it drains, giving 1 word/cycle throughput.
- Arbitration, evaluated only when accept=1:
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the source != last_src.
  - Neither valid -> no grant.
- a_ready = accept & grant_A; b_ready = accept & grant_B. Never both 1 in the same cycle.
- On a grant at posedge:
  - out <= {1'b1, src, par, seq_src, payload}.
    - src: 0 for A, 1 for B.
    - par: XOR of all payload bits (even parity).
    - seq_src: the granted source's counter value before increment.
  - Granted counter increments, wrapping 31 -> 0. The other counter holds.
  - last_src <= src; out_valid <= 1; FSM -> FULL.
- FULL with out_ready=1 and no grant -> out_valid <= 0, FSM -> EMPTY. out keeps its last value (don't-care while invalid).
- FULL with out_ready=0 -> out, out_valid, last_src and counters all hold. No ready is asserted.
- Latency: payload accepted at edge N appears on out with out_valid=1 immediately after edge N (1 cycle).
- Payloads and header fields are never altered by backpressure. Words appear in grant order.
- Header bit 31 is always 1 on valid words, acting as a frame marker.

Test Plan:
- Reset then single A: a=24'h000001, a_valid=1, out_ready=1 -> a_ready=1 in that cycle; next cycle out=32'hA0000001 (marker 1, src 0, par 1, seq 0), out_valid=1, last_src=0.
- Tie after reset: a_valid=b_valid=1 continuously, out_ready=1 -> grants A,B,A,B. out headers read 8'h80, 8'hC0, 8'h81, 8'hC1 for zero payloads. Sustains 1 word per cycle.
- Backpressure: FULL holding 32'hC0FFFFFF? Use b=24'hFFFFFF, expect header 8'hC0 (par=0). Hold out_ready=0 for 5 cycles with a_valid=1 -> out stable, a_ready=b_ready=0. Raise out_ready -> A granted in that same cycle.
- Sequence wrap: 33 consecutive A-only transfers -> 32nd word seq=31, 33rd word seq=0. B counter stays 0.
- Drain to empty: one word, then out_ready=1 with no valids -> out_valid drops next cycle, FSM EMPTY, counters unchanged.
- Reset mid-stream: reset_n=0 for one edge while FULL and both requesters valid -> out_valid=0, no ready asserted. After release, the first tie grants A with seq=0.
